// File: rtl/tick_recover.sv
// Brings the four stopwatch divider outputs into clk_in: synchronise, rising-edge strobe, per-channel period watchdog.
// Optional TICK_RECOVER_SECCNT_EN adds a 16-bit seconds counter driven by the 1Hz strobe.
module tick_recover #(
  parameter int SYNC_STAGES  = 2,
  parameter int PERIOD_FAST  = 250000,
  parameter int PERIOD_BLINK = 25000000,
  parameter int PERIOD_2HZ   = 50000000,
  parameter int PERIOD_1HZ   = 100000000,
  parameter int TOL_SHIFT    = 4,
  parameter int CNT_W        = 27
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       fast_in,
  input  logic       blink_in,
  input  logic       hz2_in,
  input  logic       hz1_in,
  input  logic       fault_clr,
  output logic [3:0] tick,
  output logic [3:0] fault,
  output logic       locked
`ifdef TICK_RECOVER_SECCNT_EN
  ,
  output logic [15:0] sec_count
`endif
);

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    RUN        = 2'd1,
    FAULT      = 2'd2
  } state_t;

  localparam logic [2:0] PRIME_DONE = 3'(SYNC_STAGES + 1);

  logic [3:0] din;
  logic [3:0] run_vec;
  logic [2:0] prime_q, prime_d;
  logic       prime_done;
  logic       locked_q, locked_d;

  assign din = {hz1_in, hz2_in, blink_in, fast_in};

  // Edge detection stays off until the synchroniser and prev flop hold real samples,
  // so an input already high when rst releases is not mistaken for a rising edge.
  always_comb begin
    prime_d = prime_q;
    if (prime_q != PRIME_DONE) prime_d = prime_q + 3'd1;
    locked_d = &run_vec;
  end

  assign prime_done = (prime_q == PRIME_DONE);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      prime_q  <= '0;
      locked_q <= 1'b0;
    end else begin
      prime_q  <= prime_d;
      locked_q <= locked_d;
    end
  end

  assign locked = locked_q;

  for (genvar i = 0; i < 4; i++) begin : g_ch
    localparam int PERIOD = (i == 0) ? PERIOD_FAST :
                            (i == 1) ? PERIOD_BLINK :
                            (i == 2) ? PERIOD_2HZ : PERIOD_1HZ;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(PERIOD + (PERIOD >> TOL_SHIFT));

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   tick_q, tick_d;
    logic                   strobe;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;

    // A strobe zeroes the counter in the cycle it would otherwise reach LIMIT, so it beats the timeout.
    always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], din[i]};
      prev_d  = sync_q[SYNC_STAGES-1];
      strobe  = sync_q[SYNC_STAGES-1] & ~prev_q & prime_done;
      tick_d  = strobe;
      cnt_inc = (cnt_q == LIMIT) ? cnt_q : cnt_q + CNT_W'(1);
      cnt_d   = strobe ? '0 : cnt_inc;
      state_d = state_q;
      case (state_q)
        WAIT_FIRST: begin
          if (strobe) state_d = RUN;
          else if (cnt_inc == LIMIT) state_d = FAULT;
        end
        RUN: begin
          if (!strobe && (cnt_inc == LIMIT)) state_d = FAULT;
        end
        default: state_d = state_q;
      endcase
      if (fault_clr) begin
        state_d = WAIT_FIRST;
        cnt_d   = '0;
      end
    end

    always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
        state_q <= WAIT_FIRST;
        sync_q  <= '0;
        prev_q  <= 1'b0;
        tick_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        sync_q  <= sync_d;
        prev_q  <= prev_d;
        tick_q  <= tick_d;
        cnt_q   <= cnt_d;
      end
    end

    assign tick[i]    = tick_q;
    assign fault[i]   = (state_q == FAULT);
    assign run_vec[i] = (state_q == RUN);
  end

`ifdef TICK_RECOVER_SECCNT_EN
  logic [15:0] sec_q, sec_d;

  always_comb begin
    sec_d = sec_q;
    if (fault_clr) sec_d = '0;
    else if (tick[3] && !fault[3]) sec_d = sec_q + 16'd1;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) sec_q <= '0;
    else     sec_q <= sec_d;
  end

  assign sec_count = sec_q;
`endif

endmodule

// File: tb/tb_tick_recover.sv
// Directed bench for tick_recover with short periods (40/400/800/1600, TOL_SHIFT=2 -> fast LIMIT=50).
// Tick is checked every cycle against an input-history model; watchdog/lock/reset points are hand-computed.
module tb_tick_recover;
  localparam int SYNC = 2;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       fault_clr;
  logic [3:0] in_v;
  logic [3:0] tick;
  logic [3:0] fault;
  logic       locked;
`ifdef TICK_RECOVER_SECCNT_EN
  logic [15:0] sec_count;
`endif

  int         checks = 0;
  int         errors = 0;
  int         ncyc = 0;
  logic [3:0] hist[$];
  logic [3:0] gen_en;
  int         ph[4];
  int         per[4] = '{40, 400, 800, 1600};

  always #5 clk_in = ~clk_in;

  tick_recover #(
    .SYNC_STAGES(SYNC),
    .PERIOD_FAST(40),
    .PERIOD_BLINK(400),
    .PERIOD_2HZ(800),
    .PERIOD_1HZ(1600),
    .TOL_SHIFT(2),
    .CNT_W(27)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
    .fast_in(in_v[0]),
    .blink_in(in_v[1]),
    .hz2_in(in_v[2]),
    .hz1_in(in_v[3]),
    .fault_clr(fault_clr),
    .tick(tick),
    .fault(fault),
    .locked(locked)
`ifdef TICK_RECOVER_SECCNT_EN
    ,
    .sec_count(sec_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value driven after edge m is sampled at edge m+1, reaches the last sync stage at m+2, tick at m+3.
  function automatic logic [3:0] exp_tick();
    if (rst || ncyc < SYNC + 2) return 4'b0000;
    return hist[ncyc-3] & ~hist[ncyc-4];
  endfunction

  task automatic step();
    if (!rst) hist.push_back(in_v);
    @(posedge clk_in);
    #1;
    if (!rst) ncyc++;
    chk("tick", {28'd0, tick}, {28'd0, exp_tick()});
    for (int i = 0; i < 4; i++) begin
      if (gen_en[i]) begin
        ph[i]   = (ph[i] + 1) % per[i];
        in_v[i] = (ph[i] < per[i] / 2);
      end
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic start_gen(input int i);
    gen_en[i] = 1'b1;
    ph[i]     = per[i] / 2;
    in_v[i]   = 1'b0;
  endtask

  task automatic wait_tick(input int idx, input int limit);
    logic found;
    found = 1'b0;
    for (int k = 0; k < limit; k++) begin
      step();
      if (tick[idx]) begin
        found = 1'b1;
        break;
      end
    end
    chk($sformatf("wait_tick%0d", idx), {31'd0, found}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1; fault_clr = 1'b0; in_v = 4'b0000; gen_en = 4'b0000;
    for (int i = 0; i < 4; i++) ph[i] = 0;

    // Reset state, then no edges: fast channel times out at cycle 50.
    steps(3);
    chk("rst_fault", {28'd0, fault}, 32'h0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
`ifdef TICK_RECOVER_SECCNT_EN
    chk("rst_sec", {16'd0, sec_count}, 32'd0);
`endif
    rst = 1'b0; ncyc = 0; hist.delete();
    steps(49);
    chk("nofault_49", {28'd0, fault}, 32'h0);
    chk("locked_idle", {31'd0, locked}, 32'd0);
    step();
    chk("fault_50", {28'd0, fault}, 32'h1);

    // Clear, then nominal square waves on all channels.
    fault_clr = 1'b1; step(); fault_clr = 1'b0;
    chk("clr_fault", {28'd0, fault}, 32'h0);
    for (int i = 0; i < 4; i++) start_gen(i);
    wait_tick(3, 1000);
    chk("lock_pre", {31'd0, locked}, 32'd0);
    step();
    chk("lock_post", {31'd0, locked}, 32'd1);
`ifdef TICK_RECOVER_SECCNT_EN
    chk("sec_first", {16'd0, sec_count}, 32'd1);
`endif
    steps(3200);
    chk("run_fault", {28'd0, fault}, 32'h0);
    chk("run_locked", {31'd0, locked}, 32'd1);
`ifdef TICK_RECOVER_SECCNT_EN
    chk("sec_run", {16'd0, sec_count}, 32'd3);
`endif

    // Drop fast edges right after a strobe: fault at +50, locked falls at +51.
    wait_tick(0, 60);
    gen_en[0] = 1'b0; in_v[0] = 1'b0;
    steps(49);
    chk("drop_49_fault", {28'd0, fault}, 32'h0);
    step();
    chk("drop_50_fault", {28'd0, fault}, 32'h1);
    chk("drop_50_locked", {31'd0, locked}, 32'd1);
    step();
    chk("drop_51_locked", {31'd0, locked}, 32'd0);
    in_v[0] = 1'b1;
    steps(2);
    chk("late_tick_wait", {31'd0, tick[0]}, 32'd0);
    step();
    chk("late_tick", {31'd0, tick[0]}, 32'd1);
    chk("late_fault", {31'd0, fault[0]}, 32'd1);

    // Boundary: strobe registered while counter is 49 wins; one cycle later loses.
    in_v[0] = 1'b0;
    steps(5);
    fault_clr = 1'b1; step(); fault_clr = 1'b0;
    chk("clr2_fault", {28'd0, fault}, 32'h0);
    steps(47);
    in_v[0] = 1'b1;
    steps(3);
    chk("b49_tick", {31'd0, tick[0]}, 32'd1);
    chk("b49_fault", {31'd0, fault[0]}, 32'd0);
    in_v[0] = 1'b0;
    steps(48);
    chk("b49_still_ok", {31'd0, fault[0]}, 32'd0);
    in_v[0] = 1'b1;
    step();
    chk("b50_fault_99", {31'd0, fault[0]}, 32'd0);
    step();
    chk("b50_fault_100", {31'd0, fault[0]}, 32'd1);
    chk("b50_tick_100", {31'd0, tick[0]}, 32'd0);
    step();
    chk("b50_tick_101", {31'd0, tick[0]}, 32'd1);

    // fault_clr together with a fast timeout and a blink tick.
    in_v[0] = 1'b0; gen_en[1] = 1'b0; in_v[1] = 1'b0;
    steps(5);
    fault_clr = 1'b1; step(); fault_clr = 1'b0;
    chk("clr3_fault", {28'd0, fault}, 32'h0);
    steps(47);
    in_v[1] = 1'b1;
    steps(2);
    fault_clr = 1'b1; step(); fault_clr = 1'b0;
    chk("clr_vs_tick", {31'd0, tick[1]}, 32'd1);
    chk("clr_vs_timeout", {28'd0, fault}, 32'h0);
    step();
    chk("clr_after", {28'd0, fault}, 32'h0);
    for (int i = 0; i < 4; i++) start_gen(i);
    wait_tick(3, 1000);
    chk("relock_pre", {31'd0, locked}, 32'd0);
    step();
    chk("relock_post", {31'd0, locked}, 32'd1);
`ifdef TICK_RECOVER_SECCNT_EN
    chk("sec_after_clr", {16'd0, sec_count}, 32'd1);
`endif

    // Asynchronous reset with hz1_in held high: no tick until a fresh rising edge.
    gen_en[3] = 1'b0; in_v[3] = 1'b1;
    steps(4);
    chk("pre_rst_locked", {31'd0, locked}, 32'd1);
    rst = 1'b1; ncyc = 0; hist.delete();
    #1;
    chk("arst_locked", {31'd0, locked}, 32'd0);
    chk("arst_fault", {28'd0, fault}, 32'h0);
    chk("arst_tick", {28'd0, tick}, 32'h0);
    steps(2);
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      chk("held_high_no_tick", {31'd0, tick[3]}, 32'd0);
    end
`ifdef TICK_RECOVER_SECCNT_EN
    chk("sec_after_rst", {16'd0, sec_count}, 32'd0);
`endif
    in_v[3] = 1'b0;
    steps(4);
    in_v[3] = 1'b1;
    steps(2);
    chk("fresh_wait", {31'd0, tick[3]}, 32'd0);
    step();
    chk("fresh_tick", {31'd0, tick[3]}, 32'd1);
    step();
    chk("fresh_tick_once", {31'd0, tick[3]}, 32'd0);
`ifdef TICK_RECOVER_SECCNT_EN
    chk("sec_fresh", {16'd0, sec_count}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
